// File: rtl/act_wb_pkg.sv
// Shared types and constants for the activation write-back unit.
package act_wb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, WRITE} act_wb_state_e;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef logic signed [7:0] int8_t;

endpackage

// File: rtl/act_wb_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty; drop_o flags a push lost on full.
module act_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot in the same cycle, so push-while-full survives if popped.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/activation_writeback_unit.sv
// Buffers per-channel int8 beats and writes one packed NHWC word per pixel to activation RAM.
// Optional ACT_WB_COORD_CHECK_EN adds a sticky coord_err_o for mismatched channel coordinates.
module activation_writeback_unit
  import act_wb_pkg::*;
#(
  parameter int SA_N       = 4,
  parameter int MAX_N      = 64,
  parameter int N_BITS     = $clog2(MAX_N),
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic [ADDR_W-1:0]                 cfg_base_i,
  input  logic [N_BITS:0]                   cfg_width_i,
  input  logic [ADDR_W-1:0]                 cfg_stride_i,
  input  logic [ADDR_W-1:0]                 cfg_offset_i,
  input  logic [SA_N-1:0]                   in_valid_i,
  input  logic [SA_N-1:0][N_BITS-1:0]       in_row_i,
  input  logic [SA_N-1:0][N_BITS-1:0]       in_col_i,
  input  int8_t [SA_N-1:0]                  in_data_i,
  output logic                              wr_valid_o,
  input  logic                              wr_ready_i,
  output logic [ADDR_W-1:0]                 wr_addr_o,
  output logic [WORD_W-1:0]                 wr_data_o,
  output logic                              overflow_o,
  output logic                              idle_o
`ifdef ACT_WB_COORD_CHECK_EN
  ,
  output logic                              coord_err_o
`endif
);

  localparam int EW_FULL = 8 + 2 * N_BITS;

  act_wb_state_e state_q, state_d;

  logic [ADDR_W-1:0] cfg_base_q, cfg_stride_q, cfg_offset_q;
  logic [N_BITS:0]   cfg_width_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              overflow_q;

  logic [SA_N-1:0]                 empty, full, drop;
  logic [BYTES_PER_WORD-1:0][7:0]  head_data;
  logic [N_BITS-1:0]               row0, col0;
  logic                            pop;

  logic [2*ADDR_W-1:0] pix_idx, addr_full;

`ifdef ACT_WB_COORD_CHECK_EN
  logic [SA_N-1:0][N_BITS-1:0] head_row, head_col;
  logic                        mismatch;
  logic                        coord_err_q;

  assign row0 = head_row[0];
  assign col0 = head_col[0];
`else
  logic unused_coords;
  assign unused_coords = ^{in_row_i[SA_N-1:1], in_col_i[SA_N-1:1]};
`endif

  for (genvar k = 0; k < SA_N; k++) begin : g_ch
`ifdef ACT_WB_COORD_CHECK_EN
    logic [EW_FULL-1:0] head_w;
    act_wb_fifo #(.W(EW_FULL), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (in_valid_i[k]),
      .pop_i   (pop),
      .din_i   ({in_row_i[k], in_col_i[k], in_data_i[k]}),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .head_o  (head_w),
      .drop_o  (drop[k])
    );
    assign {head_row[k], head_col[k], head_data[k]} = head_w;
`else
    if (k == 0) begin : g_coord
      // Only channel 0 carries coordinates; the others hold data bytes alone.
      logic [EW_FULL-1:0] head_w;
      act_wb_fifo #(.W(EW_FULL), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (in_valid_i[k]),
        .pop_i   (pop),
        .din_i   ({in_row_i[k], in_col_i[k], in_data_i[k]}),
        .full_o  (full[k]),
        .empty_o (empty[k]),
        .head_o  (head_w),
        .drop_o  (drop[k])
      );
      assign {row0, col0, head_data[k]} = head_w;
    end else begin : g_data
      act_wb_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (in_valid_i[k]),
        .pop_i   (pop),
        .din_i   (in_data_i[k]),
        .full_o  (full[k]),
        .empty_o (empty[k]),
        .head_o  (head_data[k]),
        .drop_o  (drop[k])
      );
    end
`endif
  end

  assign pop = (state_q == RUN) && (&(~empty));

  // Wide arithmetic so intermediate products never wrap before the final truncation.
  assign pix_idx   = (2*ADDR_W)'(row0) * (2*ADDR_W)'(cfg_width_q) + (2*ADDR_W)'(col0);
  assign addr_full = (2*ADDR_W)'(cfg_base_q) + pix_idx * (2*ADDR_W)'(cfg_stride_q)
                   + (2*ADDR_W)'(cfg_offset_q);

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE:  if (start_i) state_d = RUN;
      RUN: begin
        if (pop) begin
          state_d   = WRITE;
          wr_addr_d = addr_full[ADDR_W-1:0];
          wr_data_d = head_data;
        end
      end
      WRITE: if (wr_ready_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      overflow_q   <= 1'b0;
      cfg_base_q   <= '0;
      cfg_width_q  <= '0;
      cfg_stride_q <= '0;
      cfg_offset_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      overflow_q <= overflow_q | (|drop);
      if (start_i) begin
        cfg_base_q   <= cfg_base_i;
        cfg_width_q  <= cfg_width_i;
        cfg_stride_q <= cfg_stride_i;
        cfg_offset_q <= cfg_offset_i;
      end
    end
  end

`ifdef ACT_WB_COORD_CHECK_EN
  always_comb begin
    mismatch = 1'b0;
    for (int k = 1; k < SA_N; k++) begin
      if (head_row[k] != head_row[0] || head_col[k] != head_col[0]) mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i)             coord_err_q <= 1'b0;
    else if (pop && mismatch) coord_err_q <= 1'b1;
  end

  assign coord_err_o = coord_err_q;
`endif

  assign wr_valid_o = (state_q == WRITE);
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign overflow_o = overflow_q;
  assign idle_o     = (state_q != WRITE) && (&empty);

endmodule

// File: tb/tb_activation_writeback_unit.sv
// Self-checking bench: queue-based pixel model plus directed and randomized stimulus.
module tb_activation_writeback_unit;

  localparam int SA_N = 4;
  localparam int NB   = 6;
  localparam int AW   = 16;

  logic                    clk = 1'b0;
  logic                    reset_i;
  logic                    start_i;
  logic [AW-1:0]           cfg_base_i, cfg_stride_i, cfg_offset_i;
  logic [NB:0]             cfg_width_i;
  logic [SA_N-1:0]         in_valid_i;
  logic [SA_N-1:0][NB-1:0] in_row_i, in_col_i;
  logic [SA_N-1:0][7:0]    in_data_i;
  logic                    wr_valid_o, wr_ready_i;
  logic [AW-1:0]           wr_addr_o;
  logic [31:0]             wr_data_o;
  logic                    overflow_o, idle_o;
`ifdef ACT_WB_COORD_CHECK_EN
  logic                    coord_err_o;
`endif

  always #5 clk = ~clk;

  activation_writeback_unit dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .cfg_base_i   (cfg_base_i),
    .cfg_width_i  (cfg_width_i),
    .cfg_stride_i (cfg_stride_i),
    .cfg_offset_i (cfg_offset_i),
    .in_valid_i   (in_valid_i),
    .in_row_i     (in_row_i),
    .in_col_i     (in_col_i),
    .in_data_i    (in_data_i),
    .wr_valid_o   (wr_valid_o),
    .wr_ready_i   (wr_ready_i),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .overflow_o   (overflow_o),
    .idle_o       (idle_o)
`ifdef ACT_WB_COORD_CHECK_EN
    ,
    .coord_err_o  (coord_err_o)
`endif
  );

  typedef struct {int row; int col; int data;} beat_t;
  typedef struct {logic [15:0] addr; logic [31:0] data;} word_t;

  beat_t chq [4][$];
  word_t expq[$];

  int errors = 0;
  int checks = 0;
  int writes = 0;
  bit mon_en = 1'b0;
  bit exp_ovf = 1'b0;
  int m_base, m_width, m_stride, m_offset;
  int b_row[4], b_col[4], b_data[4];

  bit          prev_stall = 1'b0;
  logic [15:0] prev_addr;
  logic [31:0] prev_data;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [15:0] model_addr(int r, int c);
    longint t;
    t = longint'(m_base) + (longint'(r) * m_width + c) * m_stride + m_offset;
    return t[15:0];
  endfunction

  // A word exists once every channel has a beat waiting; coordinates come from channel 0.
  task automatic model_push(int k, int r, int c, int d);
    beat_t b;
    word_t w;
    b.row = r; b.col = c; b.data = d;
    chq[k].push_back(b);
    while (chq[0].size() > 0 && chq[1].size() > 0 && chq[2].size() > 0 && chq[3].size() > 0) begin
      w.addr = model_addr(chq[0][0].row, chq[0][0].col);
      w.data = '0;
      for (int j = 0; j < 4; j++) begin
        b = chq[j].pop_front();
        w.data[8*j +: 8] = b.data[7:0];
      end
      expq.push_back(w);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < 4; j++) chq[j].delete();
    expq.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(logic [3:0] v, logic [3:0] acc);
    for (int k = 0; k < 4; k++) begin
      in_valid_i[k] = v[k];
      in_row_i[k]   = b_row[k][NB-1:0];
      in_col_i[k]   = b_col[k][NB-1:0];
      in_data_i[k]  = b_data[k][7:0];
      if (v[k] && acc[k]) model_push(k, b_row[k], b_col[k], b_data[k]);
    end
    tick();
    in_valid_i = '0;
  endtask

  task automatic set_cfg(int base, int width, int stride, int offset);
    m_base = base; m_width = width; m_stride = stride; m_offset = offset;
    cfg_base_i   = base[AW-1:0];
    cfg_width_i  = width[NB:0];
    cfg_stride_i = stride[AW-1:0];
    cfg_offset_i = offset[AW-1:0];
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((expq.size() != 0 || !idle_o) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now("drain_timeout");
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!wr_valid_o && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now("wr_valid_timeout");
  endtask

  // Compare process: every write handshake against the model, stability under backpressure.
  always @(negedge clk) begin
    if (!reset_i) begin
      prev_stall = 1'b0;
    end else if (mon_en) begin
      chk("overflow", overflow_o, exp_ovf);
      if (prev_stall) begin
        chk("stall_valid", wr_valid_o, 1'b1);
        chk("stall_addr", wr_addr_o, prev_addr);
        chk("stall_data", wr_data_o, prev_data);
      end
      if (wr_valid_o && wr_ready_i) begin
        if (expq.size() == 0) begin
          fail_now("spurious_write");
        end else begin
          word_t w;
          w = expq.pop_front();
          chk("wr_addr", wr_addr_o, w.addr);
          chk("wr_data", wr_data_o, w.data);
        end
        writes++;
      end
      prev_stall = wr_valid_o && !wr_ready_i;
      prev_addr  = wr_addr_o;
      prev_data  = wr_data_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int cnt[4];
    int maxc, wb;
    int pix_r[$], pix_c[$];
    int rows;

    reset_i = 1'b0; start_i = 1'b0; wr_ready_i = 1'b0;
    in_valid_i = '0; in_row_i = '0; in_col_i = '0; in_data_i = '0;
    set_cfg(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_wr_valid", wr_valid_o, 1'b0);
    chk("rst_wr_addr", wr_addr_o, 16'h0);
    chk("rst_wr_data", wr_data_o, 32'h0);
    chk("rst_overflow", overflow_o, 1'b0);
    chk("rst_idle", idle_o, 1'b1);
`ifdef ACT_WB_COORD_CHECK_EN
    chk("rst_coord_err", coord_err_o, 1'b0);
`endif
    reset_i = 1'b1;
    tick();
    mon_en = 1'b1;

    // Single pixel
    set_cfg(16'h100, 8, 2, 1);
    do_start();
    wr_ready_i = 1'b1;
    w0 = writes;
    for (int k = 0; k < 4; k++) begin b_row[k] = 2; b_col[k] = 3; end
    b_data[0] = 1; b_data[1] = -2; b_data[2] = 3; b_data[3] = -4;
    strobe(4'hF, 4'hF);
    chk("model_t1_addr", expq[0].addr, 16'h0127);
    chk("model_t1_data", expq[0].data, 32'hFC03FE01);
    wait_valid(10);
    chk("t1_wr_addr", wr_addr_o, 16'h0127);
    chk("t1_wr_data", wr_data_o, 32'hFC03FE01);
    wait_drain(20);
    chk("t1_write_count", writes - w0, 1);

    // Skewed arrival: channels 0..3 sampled on edges 0,2,5,9
    wr_ready_i = 1'b0;
    w0 = writes;
    for (int k = 0; k < 4; k++) begin b_row[k] = 5; b_col[k] = 7; b_data[k] = $urandom_range(0, 255); end
    for (int i = 0; i <= 10; i++) begin
      strobe({i == 9, i == 5, i == 2, i == 0}, 4'hF);
      chk($sformatf("skew_valid_e%0d", i), wr_valid_o, (i >= 10));
    end
    wr_ready_i = 1'b1;
    wait_drain(20);
    chk("skew_write_count", writes - w0, 1);

    // Backpressure with 8 pixels streaming in
    wr_ready_i = 1'b0;
    w0 = writes;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 4; k++) begin
        b_row[k] = p; b_col[k] = p + 1; b_data[k] = $urandom_range(0, 255);
      end
      strobe(4'hF, 4'hF);
      tick();
    end
    repeat (4) tick();
    chk("bp_no_write", writes - w0, 0);
    chk("bp_overflow", overflow_o, 1'b0);
    wr_ready_i = 1'b1;
    wait_drain(60);
    chk("bp_write_count", writes - w0, 8);

    // Overflow: ten beats on ch0 into an 8-deep FIFO
    wr_ready_i = 1'b0;
    w0 = writes;
    for (int j = 0; j < 10; j++) begin
      b_row[0] = 1; b_col[0] = j; b_data[0] = $urandom_range(0, 255);
      strobe(4'b0001, (j < 8) ? 4'b0001 : 4'b0000);
      if (j == 7) chk("ovf_after_8", overflow_o, 1'b0);
      if (j == 8) begin
        chk("ovf_after_9", overflow_o, 1'b1);
        exp_ovf = 1'b1;
      end
    end
    for (int j = 0; j < 8; j++) begin
      for (int k = 1; k < 4; k++) begin b_row[k] = 1; b_col[k] = j; b_data[k] = $urandom_range(0, 255); end
      strobe(4'b1110, 4'b1110);
    end
    wr_ready_i = 1'b1;
    wait_drain(60);
    chk("ovf_write_count", writes - w0, 8);

    // Mid-operation reset while a word waits in WRITE
    wr_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin b_row[k] = 3; b_col[k] = 3; b_data[k] = $urandom_range(0, 255); end
    strobe(4'hF, 4'hF);
    wait_valid(10);
    reset_i = 1'b0;
    model_clear();
    exp_ovf = 1'b0;
    tick();
    chk("mrst_wr_valid", wr_valid_o, 1'b0);
    chk("mrst_idle", idle_o, 1'b1);
    chk("mrst_wr_addr", wr_addr_o, 16'h0);
    chk("mrst_wr_data", wr_data_o, 32'h0);
    chk("mrst_overflow", overflow_o, 1'b0);
    reset_i = 1'b1;
    wr_ready_i = 1'b1;
    w0 = writes;
    repeat (10) tick();
    chk("mrst_no_write", writes - w0, 0);

    // Beats arriving in IDLE are held until start
    set_cfg(16'h0040, 10, 3, 2);
    for (int k = 0; k < 4; k++) begin b_row[k] = 4; b_col[k] = 9; b_data[k] = $urandom_range(0, 255); end
    strobe(4'hF, 4'hF);
    repeat (4) tick();
    chk("idle_hold_valid", wr_valid_o, 1'b0);
    chk("idle_hold_busy", idle_o, 1'b0);
    chk("idle_hold_writes", writes - w0, 0);
    do_start();
    wait_drain(20);
    chk("idle_write_count", writes - w0, 1);

    // Randomized stream
    rows = $urandom_range(1, 63);
    set_cfg($urandom_range(0, 65535), $urandom_range(1, 64), $urandom_range(1, 65535),
            $urandom_range(0, 65535));
    do_start();
    w0 = writes;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [3:0] v;
      v = '0;
      wb = writes - w0;
      for (int k = 0; k < 4; k++) begin
        if (cnt[k] - wb < 6 && $urandom_range(0, 1) == 1) begin
          while (pix_r.size() <= cnt[k]) begin
            pix_r.push_back($urandom_range(0, rows - 1));
            pix_c.push_back($urandom_range(0, m_width - 1));
          end
          v[k] = 1'b1;
          b_row[k] = pix_r[cnt[k]]; b_col[k] = pix_c[cnt[k]]; b_data[k] = $urandom_range(0, 255);
          cnt[k]++;
        end
      end
      wr_ready_i = ($urandom_range(0, 9) < 7);
      strobe(v, v);
    end
    wr_ready_i = 1'b1;
    repeat (30) tick();
    maxc = 0;
    for (int k = 0; k < 4; k++) if (cnt[k] > maxc) maxc = cnt[k];
    for (int k = 0; k < 4; k++) begin
      while (cnt[k] < maxc) begin
        b_row[k] = pix_r[cnt[k]]; b_col[k] = pix_c[cnt[k]]; b_data[k] = $urandom_range(0, 255);
        cnt[k]++;
        strobe(4'(1 << k), 4'(1 << k));
      end
    end
    wait_drain(100);
    chk("rand_write_count", writes - w0, maxc);

`ifdef ACT_WB_COORD_CHECK_EN
    chk("coord_err_clean", coord_err_o, 1'b0);
    set_cfg(16'h100, 8, 2, 1);
    do_start();
    for (int k = 0; k < 4; k++) begin b_row[k] = 2; b_col[k] = 3; b_data[k] = $urandom_range(0, 255); end
    b_col[2] = 4;
    w0 = writes;
    strobe(4'hF, 4'hF);
    chk("model_coord_addr", expq[0].addr, 16'h0127);
    wait_drain(20);
    chk("coord_write_count", writes - w0, 1);
    chk("coord_err_set", coord_err_o, 1'b1);
`endif

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
